// File: rtl/message_sequencer.sv
// ---------------------------------------------------------------------------
// message_sequencer
//
// Sequences the end-of-round overlay messages (win / life lost / game over).
// An event latched in IDLE selects the message, which is shown (game frozen)
// for HOLD_FRAMES frames, then held until a fresh key press or an optional
// AUTO_FRAMES timeout. A one-cycle DONE state then issues exactly one request
// pulse back to the game-flow logic.
//
// Optional feature: define MSG_BLINK_EN to make messageVisible blink with a
// half-period of BLINK_FRAMES frames while waiting for the key.
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle pulse per video frame
//   levelCleared   pulse: all balls destroyed
//   playerHit      pulse: player touched a ball
//   livesZero      level: the hit consumed the last life
//   lastLevel      level: current level is the final one
//   keyContinue    continue key, synchronous to clk
//   message        00 none, 01 win, 10 life lost, 11 game over
//   messageVisible gate for the message bitmap drawing requests
//   freezeGame     stops ball, player and shot motion
//   nextLevelReq   one-cycle pulse: load next level
//   retryReq       one-cycle pulse: restart current level
//   restartReq     one-cycle pulse: full game restart
//   busy           high whenever the sequencer is not idle
//
// State table:
//   IDLE     | no message, game running, waiting for an event
//   SHOW     | message shown for HOLD_FRAMES frames, key ignored
//   WAIT_KEY | message shown, waiting for key edge or timeout
//   DONE     | one cycle, message cleared, request pulse issued
// ---------------------------------------------------------------------------
module message_sequencer #(
    parameter int HOLD_FRAMES  = 120,
    parameter int AUTO_FRAMES  = 0,
    parameter int BLINK_FRAMES = 15,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       levelCleared,
    input  logic       playerHit,
    input  logic       livesZero,
    input  logic       lastLevel,
    input  logic       keyContinue,
    output logic [1:0] message,
    output logic       messageVisible,
    output logic       freezeGame,
    output logic       nextLevelReq,
    output logic       retryReq,
    output logic       restartReq,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHOW, WAIT_KEY, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam bit               AUTO_EN   = (AUTO_FRAMES != 0);
    localparam logic [CNT_W-1:0] AUTO_LAST = AUTO_EN ? CNT_W'(AUTO_FRAMES - 1) : '0;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       msg_lat, msg_lat_next;
    logic             last_lat, last_lat_next;
    logic             key_prev;
    logic             key_edge;
    logic             vis_wait;

    logic [1:0]       message_d;
    logic             visible_d, freeze_d, next_d, retry_d, restart_d, busy_d;

    assign key_edge = keyContinue & ~key_prev;

    // State register; all outputs are registered from their next values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            cnt            <= '0;
            msg_lat        <= 2'b00;
            last_lat       <= 1'b0;
            key_prev       <= 1'b0;
            message        <= 2'b00;
            messageVisible <= 1'b0;
            freezeGame     <= 1'b0;
            nextLevelReq   <= 1'b0;
            retryReq       <= 1'b0;
            restartReq     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            msg_lat        <= msg_lat_next;
            last_lat       <= last_lat_next;
            key_prev       <= keyContinue;
            message        <= message_d;
            messageVisible <= visible_d;
            freezeGame     <= freeze_d;
            nextLevelReq   <= next_d;
            retryReq       <= retry_d;
            restartReq     <= restart_d;
            busy           <= busy_d;
        end
    end

    // Next-state logic. The frame counter is cleared on every state exit,
    // so it can never wrap.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        msg_lat_next  = msg_lat;
        last_lat_next = last_lat;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (playerHit) begin
                    msg_lat_next  = livesZero ? 2'b11 : 2'b10;
                    last_lat_next = lastLevel;
                    state_next    = SHOW;
                end else if (levelCleared) begin
                    msg_lat_next  = 2'b01;
                    last_lat_next = lastLevel;
                    state_next    = SHOW;
                end
            end
            SHOW: begin
                if (startOfFrame) begin
                    if (cnt == HOLD_LAST) begin
                        cnt_next   = '0;
                        state_next = WAIT_KEY;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
            end
            WAIT_KEY: begin
                if (key_edge || (AUTO_EN && startOfFrame && cnt == AUTO_LAST)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else if (AUTO_EN && startOfFrame) begin
                    cnt_next = cnt + ONE;
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

`ifdef MSG_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] blink_cnt, blink_cnt_next;
    logic             blink_vis, blink_vis_next;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_next;
            blink_vis <= blink_vis_next;
        end
    end

    // Outside WAIT_KEY the blink phase is held at "visible", so every
    // entry into WAIT_KEY starts with the message shown.
    always_comb begin
        blink_cnt_next = blink_cnt;
        blink_vis_next = blink_vis;
        if (state != WAIT_KEY) begin
            blink_cnt_next = '0;
            blink_vis_next = 1'b1;
        end else if (startOfFrame) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next = '0;
                blink_vis_next = ~blink_vis;
            end else begin
                blink_cnt_next = blink_cnt + ONE;
            end
        end
    end

    assign vis_wait = blink_vis_next;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;

    assign vis_wait = 1'b1;
`endif

    // Output values for the state being entered.
    always_comb begin
        message_d = 2'b00;
        visible_d = 1'b0;
        freeze_d  = 1'b0;
        next_d    = 1'b0;
        retry_d   = 1'b0;
        restart_d = 1'b0;
        busy_d    = 1'b0;
        case (state_next)
            IDLE: ;
            SHOW: begin
                message_d = msg_lat_next;
                visible_d = 1'b1;
                freeze_d  = 1'b1;
                busy_d    = 1'b1;
            end
            WAIT_KEY: begin
                message_d = msg_lat_next;
                visible_d = vis_wait;
                freeze_d  = 1'b1;
                busy_d    = 1'b1;
            end
            DONE: begin
                freeze_d = 1'b1;
                busy_d   = 1'b1;
                case (msg_lat_next)
                    2'b01:   begin
                        next_d    = ~last_lat_next;
                        restart_d = last_lat_next;
                    end
                    2'b10:   retry_d   = 1'b1;
                    2'b11:   restart_d = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: doc/message_sequencer.md
Name: message_sequencer

Overview:
- Sequences the end-of-round overlay messages: win, life lost and game over.
- Drives the 2-bit `message` select consumed by the message bitmaps, plus a visibility gate and a game-freeze signal.
- Holds each message for a minimum number of frames, then waits for a player key (or timeout), then issues a one-cycle request back to the game-flow logic.
- Sits between the collision/level logic and the message bitmap drawers.

Parameters:
- HOLD_FRAMES, 120, frames a message is shown before the key is accepted (1..2^CNT_W-1).
- AUTO_FRAMES, 0, frames spent in WAIT_KEY before auto-continue; 0 = wait forever.
- BLINK_FRAMES, 15, half-period of the blink in frames (used only with MSG_BLINK_EN).
- CNT_W, 8, frame-counter width.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle pulse per video frame
- levelCleared  in  1  level-pulse: all balls destroyed
- playerHit  in  1  level-pulse: player touched a ball
- livesZero  in  1  level: the hit consumed the last life
- lastLevel  in  1  level: current level is the final one
- keyContinue  in  1  raw continue key, synchronous to clk
- message  out  2  00 none, 01 win, 10 life lost, 11 game over
- messageVisible  out  1  gate for drawingRequest of the message bitmaps
- freezeGame  out  1  stops ball, player and shot motion
- nextLevelReq  out  1  one-cycle pulse: load next level
- retryReq  out  1  one-cycle pulse: restart current level
- restartReq  out  1  one-cycle pulse: full game restart
- busy  out  1  state != IDLE

Behaviour:
Reset and key sampling:
- Reset is asynchronous, active-low (resetN); the clock is clk.
- In reset: state IDLE, message 00, messageVisible 0, freezeGame 0, all request pulses 0, counters 0, keyPrev 0.
- All outputs are registered.
- The key edge is keyContinue && !keyPrev; keyPrev is registered every cycle in all states.

States:
- IDLE: outputs quiescent. An event is sampled on a clock edge; on the next cycle the block is in SHOW with message loaded, freezeGame=1 and messageVisible=1 (latency 1). Event priority within one cycle:
  - playerHit && livesZero gives 11.
  - Otherwise playerHit gives 10.
  - Otherwise levelCleared gives 01.
  - Hit beats clear in the same cycle.
- SHOW: the frame counter increments on each startOfFrame. On the cycle when the HOLD_FRAMES-th pulse is counted, the counter clears and the next state is WAIT_KEY. Key edges in SHOW are ignored; a key held through SHOW does not count, and a fresh edge is required.
- WAIT_KEY: message stays valid. Exit to DONE when either:
  - a key edge occurs, or
  - AUTO_FRAMES != 0 and AUTO_FRAMES frames have elapsed.
  - A key edge and a timeout in the same cycle give a single exit.
- DONE (exactly 1 cycle): message=00, messageVisible=0, freezeGame=1. Exactly one request pulse is asserted:
  - 01 with !lastLevel: nextLevelReq.
  - 01 with lastLevel: restartReq.
  - 10: retryReq.
  - 11: restartReq.
  - lastLevel is sampled when the event is latched, not in DONE.
  - The next state is IDLE, where freezeGame=0.

Boundary rules:
- Events arriving in SHOW, WAIT_KEY or DONE are ignored; they are not queued.
- A startOfFrame in the same cycle as the event latch is not counted.
- Counter arithmetic is unsigned CNT_W-bit and never wraps, because it is cleared on each state exit.
- Reset mid-sequence returns to IDLE immediately, with no pulse emitted.

Optional Feature:
MSG_BLINK_EN
- Defined: in WAIT_KEY, messageVisible toggles every BLINK_FRAMES startOfFrame pulses. It starts at 1 on entry to WAIT_KEY, and message stays constant throughout.
- SHOW is always steady-visible.
- Not defined: messageVisible is 1 throughout SHOW and WAIT_KEY, and the blink counter logic is absent.

Test Plan (HOLD_FRAMES=4, AUTO_FRAMES=0, BLINK_FRAMES=2):
- levelCleared pulse with lastLevel=0 → next cycle message=01, freezeGame=1. After 4 startOfFrame pulses the block is in WAIT_KEY. A key edge then gives message=00 and nextLevelReq high for exactly 1 cycle, then busy=0 and freezeGame=0.
- playerHit and levelCleared in the same cycle with livesZero=0 → message=10. The key edge yields retryReq only.
- playerHit with livesZero=1 → message=11. Key held high from before the event → no exit. Release and press again → restartReq pulse.
- Key edge after only 2 frames in SHOW → ignored, the block stays in SHOW. A second event during WAIT_KEY → message unchanged.
- AUTO_FRAMES=3 rerun, no key → DONE entered on the 3rd frame of WAIT_KEY. resetN low mid-WAIT_KEY → all outputs 0 asynchronously, and no pulse is issued.
- With MSG_BLINK_EN: in WAIT_KEY, messageVisible follows 1,1,0,0,1,1 across successive frames while message stays 01. Without the macro it stays at 1.
